// File: rtl/demux8_collect.sv
// Serial-to-parallel collector: a slot counter steers accepted bits into an 8-bit word,
// presented with a valid/ack handshake. Define DEMUX8_COLLECT_MSB_FIRST_EN for MSB-first fill.
module demux8_collect (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic       D,
    input  logic       D_valid,
    output logic       D_ready,
    output logic [7:0] En,
    output logic [2:0] Sel,
    output logic [7:0] Q,
    output logic       Q_valid,
    input  logic       Q_ack
);

`ifdef DEMUX8_COLLECT_MSB_FIRST_EN
    localparam logic [2:0] First = 3'd7;
    localparam logic [2:0] Last  = 3'd0;
`else
    localparam logic [2:0] First = 3'd0;
    localparam logic [2:0] Last  = 3'd7;
`endif

    typedef enum logic [1:0] {StIdle, StCollect, StFull} state_e;

    state_e     state_q, state_d;
    logic [2:0] sel_q, sel_d, sel_step;
    logic [7:0] q_q, q_d;
    logic       q_valid_q, q_valid_d;
    logic       d_ready_q, d_ready_d;
    logic       accept;

`ifdef DEMUX8_COLLECT_MSB_FIRST_EN
    assign sel_step = sel_q - 3'd1;
`else
    assign sel_step = sel_q + 3'd1;
`endif

    // Start wins over a bit offered in the same cycle, so the bit is neither stored nor enabled.
    assign accept = D_valid & d_ready_q & ~Start;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        En        = 8'h00;
        En[sel_q] = accept;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StCollect;
                    q_d     = 8'h00;
                    sel_d   = First;
                end
            end
            StCollect: begin
                if (Start) begin
                    q_d   = 8'h00;
                    sel_d = First;
                end else if (accept) begin
                    q_d[sel_q] = D;
                    if (sel_q == Last) begin
                        q_valid_d = 1'b1;
                        state_d   = StFull;
                        sel_d     = First;
                    end else begin
                        sel_d = sel_step;
                    end
                end
            end
            StFull: begin
                if (Q_ack) begin
                    q_valid_d = 1'b0;
                    if (Start) begin
                        state_d = StCollect;
                        q_d     = 8'h00;
                        sel_d   = First;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        d_ready_d = (state_d == StCollect);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            sel_q     <= First;
            q_q       <= 8'h00;
            q_valid_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            d_ready_q <= d_ready_d;
        end
    end

    assign D_ready = d_ready_q;
    assign Sel     = sel_q;
    assign Q       = q_q;
    assign Q_valid = q_valid_q;

endmodule
